// File: rtl/rename_unit_if.sv
// Decode/commit-facing signal bundle of the 2-wide rename stage.
// master = decode/commit side, slave = rename_unit.
interface rename_unit_if #(
  parameter int NUM_A_REGS = 32,
  parameter int NUM_P_REGS = 64
);
  localparam int FL_SIZE = NUM_P_REGS - NUM_A_REGS;
  localparam int AW      = $clog2(NUM_A_REGS);
  localparam int PW      = $clog2(NUM_P_REGS);
  localparam int CW      = $clog2(FL_SIZE + 1);

  logic          instr0_valid_i;
  logic          instr1_valid_i;
  logic [AW-1:0] instr0_rs1_i;
  logic [AW-1:0] instr0_rs2_i;
  logic [AW-1:0] instr0_rd_i;
  logic [AW-1:0] instr1_rs1_i;
  logic [AW-1:0] instr1_rs2_i;
  logic [AW-1:0] instr1_rd_i;
  logic          instr0_regwrite_i;
  logic          instr1_regwrite_i;
  logic          rob_full_i;
  logic          free_en0_i;
  logic          free_en1_i;
  logic [PW-1:0] free_preg0_i;
  logic [PW-1:0] free_preg1_i;
  logic          stall_o;
  logic          ren0_valid_o;
  logic          ren1_valid_o;
  logic [PW-1:0] ren0_ps1_o;
  logic [PW-1:0] ren0_ps2_o;
  logic [PW-1:0] ren1_ps1_o;
  logic [PW-1:0] ren1_ps2_o;
  logic [PW-1:0] ren0_pd_o;
  logic [PW-1:0] ren1_pd_o;
  logic [PW-1:0] ren0_old_pd_o;
  logic [PW-1:0] ren1_old_pd_o;
  logic [CW-1:0] free_count_o;

  modport master (
    output instr0_valid_i, instr1_valid_i,
    output instr0_rs1_i, instr0_rs2_i, instr0_rd_i,
    output instr1_rs1_i, instr1_rs2_i, instr1_rd_i,
    output instr0_regwrite_i, instr1_regwrite_i, rob_full_i,
    output free_en0_i, free_en1_i, free_preg0_i, free_preg1_i,
    input  stall_o, ren0_valid_o, ren1_valid_o,
    input  ren0_ps1_o, ren0_ps2_o, ren1_ps1_o, ren1_ps2_o,
    input  ren0_pd_o, ren1_pd_o, ren0_old_pd_o, ren1_old_pd_o,
    input  free_count_o
  );

  modport slave (
    input  instr0_valid_i, instr1_valid_i,
    input  instr0_rs1_i, instr0_rs2_i, instr0_rd_i,
    input  instr1_rs1_i, instr1_rs2_i, instr1_rd_i,
    input  instr0_regwrite_i, instr1_regwrite_i, rob_full_i,
    input  free_en0_i, free_en1_i, free_preg0_i, free_preg1_i,
    output stall_o, ren0_valid_o, ren1_valid_o,
    output ren0_ps1_o, ren0_ps2_o, ren1_ps1_o, ren1_ps2_o,
    output ren0_pd_o, ren1_pd_o, ren0_old_pd_o, ren1_old_pd_o,
    output free_count_o
  );
endinterface

// File: rtl/rename_unit.sv
// 2-wide register rename: RAT lookup with intra-group bypass plus a circular free list.
// Optional FREELIST_CHECK_EN: drops double/overflowing frees and reports illegal slot use.
module rename_unit #(
  parameter int NUM_A_REGS = 32,
  parameter int NUM_P_REGS = 64,
  parameter int FL_SIZE    = NUM_P_REGS - NUM_A_REGS
) (
  input logic         clk_i,
  input logic         rst_i,
  rename_unit_if.slave bus
);
  localparam int AW = $clog2(NUM_A_REGS);
  localparam int PW = $clog2(NUM_P_REGS);
  localparam int FW = (FL_SIZE > 1) ? $clog2(FL_SIZE) : 1;
  localparam int CW = $clog2(FL_SIZE + 1);
  localparam logic [AW-1:0] A0 = {AW{1'b0}};
  localparam logic [PW-1:0] P0 = {PW{1'b0}};

  logic [PW-1:0] rat_r [NUM_A_REGS];
  logic [PW-1:0] fl_r [FL_SIZE];
  logic [FW-1:0] head_r, tail_r;
  logic [CW-1:0] count_r;

  logic          stall_s, take0_s, take1_s, alloc0_s, alloc1_s;
  logic          free0_ok_s, free1_ok_s;
  logic [1:0]    n_alloc_s, n_free_s;
  logic [FW-1:0] head_p1_s, tail_w1_s;
  logic [PW-1:0] pd0_s, pd1_s, old0_s, old1_s;
  logic [PW-1:0] ps1_0_s, ps2_0_s, ps1_1_s, ps2_1_s;

  logic          ren0_valid_r, ren1_valid_r;
  logic [PW-1:0] ren0_ps1_r, ren0_ps2_r, ren1_ps1_r, ren1_ps2_r;
  logic [PW-1:0] ren0_pd_r, ren1_pd_r, ren0_old_pd_r, ren1_old_pd_r;

  function automatic logic [FW-1:0] ptr_add(input logic [FW-1:0] ptr, input logic [1:0] n);
    logic [FW:0] sum;
    sum = {1'b0, ptr} + (FW+1)'(n);
    if (sum >= (FW+1)'(FL_SIZE)) sum = sum - (FW+1)'(FL_SIZE);
    else sum = sum;
    return sum[FW-1:0];
  endfunction

  // Conservative stall: two free entries are demanded whatever the group needs.
  assign stall_s = bus.rob_full_i | (count_r < CW'(2));

  // Allocation, source lookup and previous-mapping selection for the group.
  always_comb begin
    take0_s   = ~stall_s & bus.instr0_valid_i;
    take1_s   = ~stall_s & bus.instr1_valid_i;
    alloc0_s  = take0_s & bus.instr0_regwrite_i & (bus.instr0_rd_i != A0);
    alloc1_s  = take1_s & bus.instr1_regwrite_i & (bus.instr1_rd_i != A0);
    n_alloc_s = 2'(alloc0_s) + 2'(alloc1_s);
    head_p1_s = ptr_add(head_r, 2'd1);
    pd0_s     = alloc0_s ? fl_r[head_r] : P0;
    pd1_s     = alloc1_s ? (alloc0_s ? fl_r[head_p1_s] : fl_r[head_r]) : P0;
    old0_s    = alloc0_s ? rat_r[bus.instr0_rd_i] : P0;
    if (alloc1_s && alloc0_s && (bus.instr1_rd_i == bus.instr0_rd_i)) old1_s = pd0_s;
    else if (alloc1_s) old1_s = rat_r[bus.instr1_rd_i];
    else old1_s = P0;
    ps1_0_s = (bus.instr0_rs1_i == A0) ? P0 : rat_r[bus.instr0_rs1_i];
    ps2_0_s = (bus.instr0_rs2_i == A0) ? P0 : rat_r[bus.instr0_rs2_i];
    // Slot 1 sees slot 0's new mapping before it reaches the RAT.
    if (bus.instr1_rs1_i == A0) ps1_1_s = P0;
    else if (alloc0_s && (bus.instr1_rs1_i == bus.instr0_rd_i)) ps1_1_s = pd0_s;
    else ps1_1_s = rat_r[bus.instr1_rs1_i];
    if (bus.instr1_rs2_i == A0) ps2_1_s = P0;
    else if (alloc0_s && (bus.instr1_rs2_i == bus.instr0_rd_i)) ps2_1_s = pd0_s;
    else ps2_1_s = rat_r[bus.instr1_rs2_i];
  end

`ifdef FREELIST_CHECK_EN
  logic [NUM_P_REGS-1:0] member_r;
  logic [CW:0]           room_s;

  // Accept a free only if the register is not already queued and the list has room.
  always_comb begin
    room_s     = {1'b0, count_r} - (CW+1)'(n_alloc_s);
    free0_ok_s = bus.free_en0_i & (bus.free_preg0_i != P0) & ~member_r[bus.free_preg0_i]
                 & (room_s < (CW+1)'(FL_SIZE));
    free1_ok_s = bus.free_en1_i & (bus.free_preg1_i != P0) & ~member_r[bus.free_preg1_i]
                 & ~(free0_ok_s & (bus.free_preg1_i == bus.free_preg0_i))
                 & ((room_s + (CW+1)'(free0_ok_s)) < (CW+1)'(FL_SIZE));
  end

  // Membership tracking and error reporting.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NUM_P_REGS; p++) member_r[p] <= (p >= NUM_A_REGS);
    end else begin
      if (alloc0_s) member_r[pd0_s] <= 1'b0;
      if (alloc1_s) member_r[pd1_s] <= 1'b0;
      if (free0_ok_s) member_r[bus.free_preg0_i] <= 1'b1;
      if (free1_ok_s) member_r[bus.free_preg1_i] <= 1'b1;
      if ((bus.free_en0_i && (bus.free_preg0_i != P0) && !free0_ok_s) ||
          (bus.free_en1_i && (bus.free_preg1_i != P0) && !free1_ok_s))
        $error("Error freeing physical register");
      if (bus.instr1_valid_i && !bus.instr0_valid_i)
        $error("Error: instr1_valid_i asserted without instr0_valid_i");
    end
  end
`else
  // Every free except p0 is pushed.
  always_comb begin
    free0_ok_s = bus.free_en0_i & (bus.free_preg0_i != P0);
    free1_ok_s = bus.free_en1_i & (bus.free_preg1_i != P0);
  end
`endif

  // Free-list tail positions for this cycle's pushes.
  always_comb begin
    n_free_s  = 2'(free0_ok_s) + 2'(free1_ok_s);
    tail_w1_s = free0_ok_s ? ptr_add(tail_r, 2'd1) : tail_r;
  end

  // RAT and free-list state; slot 1 writes last so it wins on a shared rd.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_A_REGS; i++) rat_r[i] <= PW'(i);
      for (int i = 0; i < FL_SIZE; i++) fl_r[i] <= PW'(NUM_A_REGS + i);
      head_r  <= {FW{1'b0}};
      tail_r  <= {FW{1'b0}};
      count_r <= CW'(FL_SIZE);
    end else begin
      if (alloc0_s) rat_r[bus.instr0_rd_i] <= pd0_s;
      if (alloc1_s) rat_r[bus.instr1_rd_i] <= pd1_s;
      if (free0_ok_s) fl_r[tail_r] <= bus.free_preg0_i;
      if (free1_ok_s) fl_r[tail_w1_s] <= bus.free_preg1_i;
      head_r  <= ptr_add(head_r, n_alloc_s);
      tail_r  <= ptr_add(tail_r, n_free_s);
      count_r <= count_r - CW'(n_alloc_s) + CW'(n_free_s);
    end
  end

  // Registered rename results, valid for exactly one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ren0_valid_r  <= 1'b0;  ren1_valid_r  <= 1'b0;
      ren0_ps1_r    <= P0;    ren0_ps2_r    <= P0;
      ren1_ps1_r    <= P0;    ren1_ps2_r    <= P0;
      ren0_pd_r     <= P0;    ren1_pd_r     <= P0;
      ren0_old_pd_r <= P0;    ren1_old_pd_r <= P0;
    end else begin
      ren0_valid_r  <= take0_s;
      ren1_valid_r  <= take1_s;
      ren0_ps1_r    <= take0_s ? ps1_0_s : P0;
      ren0_ps2_r    <= take0_s ? ps2_0_s : P0;
      ren1_ps1_r    <= take1_s ? ps1_1_s : P0;
      ren1_ps2_r    <= take1_s ? ps2_1_s : P0;
      ren0_pd_r     <= pd0_s;
      ren1_pd_r     <= pd1_s;
      ren0_old_pd_r <= old0_s;
      ren1_old_pd_r <= old1_s;
    end
  end

  assign bus.stall_o       = stall_s;
  assign bus.ren0_valid_o  = ren0_valid_r;
  assign bus.ren1_valid_o  = ren1_valid_r;
  assign bus.ren0_ps1_o    = ren0_ps1_r;
  assign bus.ren0_ps2_o    = ren0_ps2_r;
  assign bus.ren1_ps1_o    = ren1_ps1_r;
  assign bus.ren1_ps2_o    = ren1_ps2_r;
  assign bus.ren0_pd_o     = ren0_pd_r;
  assign bus.ren1_pd_o     = ren1_pd_r;
  assign bus.ren0_old_pd_o = ren0_old_pd_r;
  assign bus.ren1_old_pd_o = ren1_old_pd_r;
  assign bus.free_count_o  = count_r;
endmodule

// File: tb/tb_rename_unit.sv
// Bench for rename_unit: program-order rename model (array RAT + queue free list)
// checked every cycle, plus hand-computed literal expectations.
module tb_rename_unit;
  localparam int NA = 32;
  localparam int NP = 64;
  localparam int AW = $clog2(NA);
  localparam int PW = $clog2(NP);

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks = 0;
  int   failures = 0;

  always #5 clk_i = ~clk_i;

  rename_unit_if #(.NUM_A_REGS(NA), .NUM_P_REGS(NP)) bus ();
  rename_unit #(.NUM_A_REGS(NA), .NUM_P_REGS(NP)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  // Model state: the RAT as a plain array, the free list as a FIFO queue.
  int m_rat [NA];
  int m_fl [$];
  int retire_q [$];
  int e_v0, e_v1, e_ps1_0, e_ps2_0, e_ps1_1, e_ps2_1, e_pd0, e_pd1, e_old0, e_old1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < NA; a++) m_rat[a] = a;
    m_fl.delete();
    for (int p = NA; p < NP; p++) m_fl.push_back(p);
    retire_q.delete();
    e_v0 = 0; e_v1 = 0; e_ps1_0 = 0; e_ps2_0 = 0; e_ps1_1 = 0; e_ps2_1 = 0;
    e_pd0 = 0; e_pd1 = 0; e_old0 = 0; e_old1 = 0;
  endtask

  // Rename the two slots strictly in program order; slot 1 sees slot 0's effects.
  task automatic model_step();
    bit stall;
    int rd;
    stall = bus.rob_full_i || (m_fl.size() < 2);
    e_v0 = int'(!stall && bus.instr0_valid_i);
    e_v1 = int'(!stall && bus.instr1_valid_i);
    e_pd0 = 0; e_old0 = 0; e_pd1 = 0; e_old1 = 0;
    e_ps1_0 = m_rat[bus.instr0_rs1_i];
    e_ps2_0 = m_rat[bus.instr0_rs2_i];
    rd = int'(bus.instr0_rd_i);
    if (e_v0 != 0 && bus.instr0_regwrite_i && rd != 0) begin
      e_old0 = m_rat[rd];
      e_pd0  = m_fl.pop_front();
      m_rat[rd] = e_pd0;
      retire_q.push_back(e_old0);
    end
    e_ps1_1 = m_rat[bus.instr1_rs1_i];
    e_ps2_1 = m_rat[bus.instr1_rs2_i];
    rd = int'(bus.instr1_rd_i);
    if (e_v1 != 0 && bus.instr1_regwrite_i && rd != 0) begin
      e_old1 = m_rat[rd];
      e_pd1  = m_fl.pop_front();
      m_rat[rd] = e_pd1;
      retire_q.push_back(e_old1);
    end
    if (bus.free_en0_i && int'(bus.free_preg0_i) != 0) m_fl.push_back(int'(bus.free_preg0_i));
    if (bus.free_en1_i && int'(bus.free_preg1_i) != 0) m_fl.push_back(int'(bus.free_preg1_i));
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) model_reset();
    else model_step();
  end

  // Single compare process: outputs vs model, on every falling edge out of reset.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("stall", int'(bus.stall_o), int'(bus.rob_full_i || (m_fl.size() < 2)));
      chk("ren0_valid", int'(bus.ren0_valid_o), e_v0);
      chk("ren1_valid", int'(bus.ren1_valid_o), e_v1);
      chk("free_count", int'(bus.free_count_o), m_fl.size());
      if (e_v0 != 0) begin
        chk("ren0_ps1", int'(bus.ren0_ps1_o), e_ps1_0);
        chk("ren0_ps2", int'(bus.ren0_ps2_o), e_ps2_0);
        chk("ren0_pd", int'(bus.ren0_pd_o), e_pd0);
        chk("ren0_old_pd", int'(bus.ren0_old_pd_o), e_old0);
      end
      if (e_v1 != 0) begin
        chk("ren1_ps1", int'(bus.ren1_ps1_o), e_ps1_1);
        chk("ren1_ps2", int'(bus.ren1_ps2_o), e_ps2_1);
        chk("ren1_pd", int'(bus.ren1_pd_o), e_pd1);
        chk("ren1_old_pd", int'(bus.ren1_old_pd_o), e_old1);
      end
    end
  end

  task automatic clr();
    bus.instr0_valid_i = 1'b0; bus.instr1_valid_i = 1'b0;
    bus.instr0_rs1_i = '0; bus.instr0_rs2_i = '0; bus.instr0_rd_i = '0;
    bus.instr1_rs1_i = '0; bus.instr1_rs2_i = '0; bus.instr1_rd_i = '0;
    bus.instr0_regwrite_i = 1'b0; bus.instr1_regwrite_i = 1'b0;
    bus.rob_full_i = 1'b0;
    bus.free_en0_i = 1'b0; bus.free_en1_i = 1'b0;
    bus.free_preg0_i = '0; bus.free_preg1_i = '0;
  endtask

  task automatic grp0(input int v, input int rw, input int rs1, input int rs2, input int rd);
    bus.instr0_valid_i = (v != 0); bus.instr0_regwrite_i = (rw != 0);
    bus.instr0_rs1_i = AW'(rs1); bus.instr0_rs2_i = AW'(rs2); bus.instr0_rd_i = AW'(rd);
  endtask

  task automatic grp1(input int v, input int rw, input int rs1, input int rs2, input int rd);
    bus.instr1_valid_i = (v != 0); bus.instr1_regwrite_i = (rw != 0);
    bus.instr1_rs1_i = AW'(rs1); bus.instr1_rs2_i = AW'(rs2); bus.instr1_rd_i = AW'(rd);
  endtask

  task automatic frees(input int en0, input int p0, input int en1, input int p1);
    bus.free_en0_i = (en0 != 0); bus.free_preg0_i = PW'(p0);
    bus.free_en1_i = (en1 != 0); bus.free_preg1_i = PW'(p1);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Asserted mid-cycle while inputs may still be live; discards that group.
  task automatic do_reset();
    rst_i = 1'b1;
    @(negedge clk_i); #2;
    clr();
    @(negedge clk_i); #2;
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    model_reset();
    @(negedge clk_i); #2;
    @(negedge clk_i); #2;
    rst_i = 1'b0;
    tick();
    chk("reset_count", int'(bus.free_count_o), 32);
    chk("reset_stall", int'(bus.stall_o), 0);
    chk("reset_valid0", int'(bus.ren0_valid_o), 0);

    // add x5<-x1,x2 ; add x6<-x5,x3
    grp0(1, 1, 1, 2, 5); grp1(1, 1, 5, 3, 6);
    tick(); clr();
    chk("t1_pd0", int'(bus.ren0_pd_o), 32);
    chk("t1_old0", int'(bus.ren0_old_pd_o), 5);
    chk("t1_ps1_0", int'(bus.ren0_ps1_o), 1);
    chk("t1_pd1", int'(bus.ren1_pd_o), 33);
    chk("t1_ps1_1", int'(bus.ren1_ps1_o), 32);
    chk("t1_old1", int'(bus.ren1_old_pd_o), 6);
    chk("t1_count", int'(bus.free_count_o), 30);

    // Both slots write x7, reset hitting while a group is presented.
    grp0(1, 1, 3, 4, 9);
    do_reset();
    grp0(1, 1, 0, 0, 7); grp1(1, 1, 0, 0, 7);
    tick(); clr();
    chk("t2_pd0", int'(bus.ren0_pd_o), 32);
    chk("t2_old0", int'(bus.ren0_old_pd_o), 7);
    chk("t2_old1", int'(bus.ren1_old_pd_o), 32);
    chk("t2_pd1", int'(bus.ren1_pd_o), 33);
    grp0(1, 0, 7, 0, 0);
    tick(); clr();
    chk("t2_read_x7", int'(bus.ren0_ps1_o), 33);

    // Drain to one entry, stall, free p7, recover.
    do_reset();
    for (int i = 0; i < 31; i++) begin
      grp0(1, 1, 0, 0, (i % 31) + 1);
      tick();
    end
    clr();
    chk("t3_count1", int'(bus.free_count_o), 1);
    chk("t3_stall", int'(bus.stall_o), 1);
    grp0(1, 1, 0, 0, 3);
    tick(); clr();
    chk("t3_stalled_valid", int'(bus.ren0_valid_o), 0);
    chk("t3_count_hold", int'(bus.free_count_o), 1);
    frees(1, 7, 0, 0);
    tick(); clr();
    chk("t3_count2", int'(bus.free_count_o), 2);
    chk("t3_stall_drop", int'(bus.stall_o), 0);
    grp0(1, 1, 0, 0, 4);
    tick(); clr();
    chk("t3_pd_after", int'(bus.ren0_pd_o), 63);

    // ROB full holds everything.
    do_reset();
    bus.rob_full_i = 1'b1;
    grp0(1, 1, 0, 0, 9);
    #1 chk("t4_stall", int'(bus.stall_o), 1);
    tick();
    chk("t4_valid", int'(bus.ren0_valid_o), 0);
    chk("t4_count", int'(bus.free_count_o), 32);
    bus.rob_full_i = 1'b0;
    tick(); clr();
    chk("t4_pd", int'(bus.ren0_pd_o), 32);

    // Full drain, refill with p1..p32, head wraps.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      grp0(1, 1, 0, 0, ((2 * k) % 31) + 1);
      grp1(1, 1, 0, 0, ((2 * k + 1) % 31) + 1);
      tick();
    end
    clr();
    chk("t5_empty", int'(bus.free_count_o), 0);
    for (int j = 0; j < 16; j++) begin
      frees(1, 2 * j + 1, 1, 2 * j + 2);
      tick();
    end
    clr();
    chk("t5_full", int'(bus.free_count_o), 32);
    grp0(1, 1, 0, 0, 2); grp1(1, 1, 0, 0, 3);
    tick(); clr();
    chk("t5_wrap_pd0", int'(bus.ren0_pd_o), 1);
    chk("t5_wrap_pd1", int'(bus.ren1_pd_o), 2);

    // x0 destination, p0 free dropped, free+alloc in the same cycle when full.
    do_reset();
    grp0(1, 1, 0, 5, 0); frees(1, 0, 0, 0);
    tick(); clr();
    chk("t6_pd_x0", int'(bus.ren0_pd_o), 0);
    chk("t6_ps1_x0", int'(bus.ren0_ps1_o), 0);
    chk("t6_valid", int'(bus.ren0_valid_o), 1);
    chk("t6_count", int'(bus.free_count_o), 32);
    grp0(1, 1, 0, 0, 5); frees(1, 5, 0, 0);
    tick(); clr();
    chk("t6_swap_count", int'(bus.free_count_o), 32);

    // Mixed traffic: bypasses, non-writing slots, stalls with frees from retired mappings.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      clr();
      grp0(1, int'((i % 5) != 4), i % 32, (i * 3) % 32, (i * 7 + 1) % 32);
      grp1(int'((i % 3) != 2), int'((i % 4) != 3), (i * 7 + 1) % 32, (i * 11) % 32,
           ((i % 6) == 0) ? (i * 7 + 1) % 32 : (i * 13 + 2) % 32);
      if (retire_q.size() > 0 && (i % 3) != 0) bus.free_en0_i = 1'b1;
      if (bus.free_en0_i) bus.free_preg0_i = PW'(retire_q.pop_front());
      if (retire_q.size() > 0 && (i % 2) == 1) begin
        bus.free_en1_i = 1'b1;
        bus.free_preg1_i = PW'(retire_q.pop_front());
      end
      tick();
    end
    clr();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rename_unit.md
Name: rename_unit

Overview:
- 2-wide register rename stage directly upstream of the reorder buffer.
- Maps architectural source and destination registers to physical registers using a register alias table (RAT) and a circular free list.
- Produces dest / old_dest / physical source tags for the ROB reserve ports and the reservation stations.
- Reclaims physical registers that the commit path frees at retire.

Parameters:
- NUM_A_REGS, 32, architectural registers; x0 is hard-wired to p0.
- NUM_P_REGS, 64, physical registers; must exceed NUM_A_REGS.
- FL_SIZE, NUM_P_REGS-NUM_A_REGS, free-list capacity in entries.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- instr0_valid_i  in  1  decode slot 0 holds an instruction.
- instr1_valid_i  in  1  decode slot 1 holds an instruction; only legal with instr0_valid_i.
- instr0_rs1_i, instr0_rs2_i, instr0_rd_i  in  $clog2(NUM_A_REGS) each  slot 0 architectural registers.
- instr1_rs1_i, instr1_rs2_i, instr1_rd_i  in  $clog2(NUM_A_REGS) each  slot 1 architectural registers.
- instr0_regwrite_i, instr1_regwrite_i  in  1 each  instruction writes rd.
- rob_full_i  in  1  ROB cannot take two entries this cycle.
- free_en0_i, free_en1_i  in  1 each  commit returns a physical register.
- free_preg0_i, free_preg1_i  in  $clog2(NUM_P_REGS) each  register being returned.
- stall_o  out  1  decode must hold both slots.
- ren0_valid_o, ren1_valid_o  out  1 each  renamed slot valid; feeds the ROB en_reserve inputs.
- ren0_ps1_o, ren0_ps2_o, ren1_ps1_o, ren1_ps2_o  out  $clog2(NUM_P_REGS) each  physical sources.
- ren0_pd_o, ren1_pd_o  out  $clog2(NUM_P_REGS) each  new physical destination.
- ren0_old_pd_o, ren1_old_pd_o  out  $clog2(NUM_P_REGS) each  previous mapping of rd, freed at commit.
- free_count_o  out  $clog2(FL_SIZE+1)  current free-list occupancy.

Behaviour:
- Reset state:
  - RAT[a] = a for all a.
  - Free list holds p(NUM_A_REGS)..p(NUM_P_REGS-1) in ascending order; head = 0, tail = 0 (wrapped), count = FL_SIZE.
  - All ren*_o outputs and valids = 0; stall_o = 0.
  - Reset asserted mid-operation discards the in-flight group and restores this state immediately.
- Stall:
  - stall_o is combinational: rob_full_i OR count < 2.
  - The conservative count < 2 check applies regardless of how many slots actually need allocation.
- Allocation:
  - A slot allocates when valid AND regwrite AND rd != 0.
  - Slot 0 pops the free-list head first; slot 1 pops the next entry.
  - Head and count advance by the number of allocations, modulo FL_SIZE for wrap.
  - Non-allocating slot: pd = 0, old_pd = 0; RAT unchanged.
- Source lookup (slot 1):
  - rs1/rs2 that equal slot 0 rd, when slot 0 allocates, take slot 0 pd (intra-group bypass); otherwise they read the RAT.
  - rs = 0 always yields p0.
- Old destination:
  - old_pd = RAT[rd] before this group.
  - If both slots allocate with the same rd, slot 1 old_pd = slot 0 pd and the RAT ends holding slot 1 pd.
- Latency:
  - Outputs are registered; a group accepted at edge N appears on ren*_o after edge N and is held for one cycle only.
  - Stalled cycle: ren*_valid_o = 0 next cycle; RAT and free list are unchanged by allocation.
- Frees:
  - Frees push at the tail, slot 0 first, and are processed even during stall.
  - A same-cycle free and allocation both apply: the stall decision and the pops use the count before frees, so freed registers are poppable the next cycle.
  - Net count update = count - allocs + frees.
- Freeing p0 is dropped in all builds.

Optional Feature:
- FREELIST_CHECK_EN defined:
  - A free that would make count exceed FL_SIZE, or a free of a register already in the free list (membership bit vector), prints "Error freeing physical register" and is dropped.
  - instr1_valid_i without instr0_valid_i prints an error.
- FREELIST_CHECK_EN undefined:
  - No membership vector; all frees except p0 are pushed unconditionally.
  - Overflow behaviour is unspecified.

Test Plan:
- Reset, then slot0 add x5←x1,x2 and slot1 add x6←x5,x3 → next cycle ren0_pd = 32, ren0_old_pd = 5, ren0_ps1 = 1; ren1_pd = 33, ren1_ps1 = 32, ren1_old_pd = 6; free_count = 30.
- Both slots write x7 → ren0_pd = 32, ren0_old_pd = 7, ren1_old_pd = 32, ren1_pd = 33; a later read of x7 yields 33.
- Rename 31 writes one per cycle → count = 1, stall_o = 1; next group yields valid = 0; free p7 → count = 2, stall_o drops next cycle.
- rob_full_i = 1 with count = 32 → stall_o = 1, no pops, valids 0; deassert → rename proceeds with pd = 32.
- Rename 32 registers, free all 32 back, rename 2 more → pds are the first two freed registers, confirming head wrap at FL_SIZE.
- rd = x0 with regwrite, plus rs1 = x0 → pd = 0, ps1 = 0, count unchanged. With FREELIST_CHECK_EN, double-free of p40 → error printed and count unchanged.
